lru_replacement: RTL

LRU_REPLACEMENT -- requirements
Module: lru_replacement

---
 rtl/lru_replacement.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lru_replacement.sv
// True-LRU victim selection with per-set age permutations, set-by-set INIT sweep and a serial way scan.
// Ports: clk, rst_n, index, access_valid/access_way (touch), replace (request), block_replace/replace_way (grant), busy, drop_count.
module lru_replacement #(
  parameter int way       = 4,
  parameter int set       = 512,
  parameter int set_index = $clog2(set)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [set_index-1:0] index,
  input  logic                 access_valid,
  input  logic [4:0]           access_way,
  input  logic                 replace,
  output logic                 block_replace,
  output logic [4:0]           replace_way,
  output logic                 busy,
  output logic [31:0]          drop_count
);

  localparam int AW = (way > 1) ? $clog2(way) : 1;

  typedef logic [way-1:0][AW-1:0] row_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SCAN,
    S_GRANT,
    S_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [set_index-1:0] init_cnt_q, init_cnt_d;
  logic [AW-1:0]        scan_cnt_q, scan_cnt_d;
  logic [set_index-1:0] idx_q, idx_d;
  logic [AW-1:0]        victim_q, victim_d;
  logic                 block_q, block_d;
  logic [4:0]           rway_q, rway_d;
  logic                 busy_q, busy_d;
  logic [31:0]          drop_q, drop_d;

  row_t                 age_q [set];
  logic                 age_we;
  logic [set_index-1:0] age_wr_idx;
  row_t                 age_wr_row;
  row_t                 ident_row;
  row_t                 idx_row;
  row_t                 lat_row;

  // Touched way becomes MRU; every younger way ages by one.
  function automatic row_t touch(input row_t r, input logic [AW-1:0] w);
    row_t o;
    o = r;
    for (int j = 0; j < way; j++) begin
      if (r[j] < r[w]) o[j] = r[j] + 1'b1;
    end
    o[w] = '0;
    return o;
  endfunction

  always_comb begin
    for (int j = 0; j < way; j++) ident_row[j] = AW'(j);
  end

  assign idx_row = age_q[index];
  assign lat_row = age_q[idx_q];

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    scan_cnt_d = scan_cnt_q;
    idx_d      = idx_q;
    victim_d   = victim_q;
    block_d    = 1'b0;
    rway_d     = rway_q;
    drop_d     = drop_q;
    age_we     = 1'b0;
    age_wr_idx = idx_q;
    age_wr_row = lat_row;

    unique case (1'b1)
      state_q == S_INIT: begin
        age_we     = 1'b1;
        age_wr_idx = init_cnt_q;
        age_wr_row = ident_row;
        if (init_cnt_q == set_index'(set - 1)) begin
          state_d = S_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      state_q == S_IDLE: begin
        if (access_valid && (int'(access_way) < way)) begin
          age_we     = 1'b1;
          age_wr_idx = index;
          age_wr_row = touch(idx_row, access_way[AW-1:0]);
        end
        if (replace) begin
          state_d    = S_SCAN;
          idx_d      = index;
          scan_cnt_d = '0;
        end
      end
      state_q == S_SCAN: begin
        if (lat_row[scan_cnt_q] == AW'(way - 1)) victim_d = scan_cnt_q;
        if (scan_cnt_q == AW'(way - 1)) begin
          state_d = S_GRANT;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      state_q == S_GRANT: begin
        block_d         = 1'b1;
        rway_d          = '0;
        rway_d[AW-1:0]  = victim_q;
        age_we          = 1'b1;
        age_wr_idx      = idx_q;
        age_wr_row      = touch(lat_row, victim_q);
        state_d         = S_WAIT;
      end
      state_q == S_WAIT: begin
        if (!replace) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    // Notices outside IDLE are lost; count them (wraps naturally).
    if (access_valid && state_q != S_IDLE) drop_d = drop_q + 32'd1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      victim_q   <= '0;
      block_q    <= 1'b0;
      rway_q     <= '0;
      busy_q     <= 1'b1;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      victim_q   <= victim_d;
      block_q    <= block_d;
      rway_q     <= rway_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  // Age storage is never read before INIT rewrites it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (age_we) age_q[age_wr_idx] <= age_wr_row;
  end

  assign block_replace = block_q;
  assign replace_way   = rway_q;
  assign busy          = busy_q;
  assign drop_count    = drop_q;

endmodule
